// File: rtl/riscv_instr_realigner.sv
// Realigns 32-bit prefetch words into whole RV32IC instructions, holding at most
// one upper-halfword residue between words for compressed and spanning instructions.
//
// state   | meaning
// ALIGNED | no residue held; next instruction starts in the incoming fetch word
// RESIDUE | res_q holds the upper halfword of a popped word, which is the next instruction start
module riscv_instr_realigner #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  fetch_valid_i,
    output logic                  fetch_ready_o,
    input  logic [31:0]           fetch_rdata_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    input  logic                  fetch_is_hwlp_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_is_compressed_o,
    output logic                  instr_is_hwlp_o,
    output logic                  residue_valid_o
);

    typedef enum logic {
        ALIGNED = 1'b0,
        RESIDUE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             res_q, res_d;
    logic [ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
    logic                    res_hwlp_q, res_hwlp_d;

    logic                    valid;
    logic                    pop;
    logic [31:0]             rdata;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    hwlp;

    logic [15:0]             fetch_lo;
    logic [15:0]             fetch_hi;
    logic                    lo_compressed;
    logic                    hi_compressed;
    logic                    res_compressed;
    logic [ADDR_WIDTH-1:0]   fetch_res_addr;
    logic                    unused_addr_bit;

    assign fetch_lo        = fetch_rdata_i[15:0];
    assign fetch_hi        = fetch_rdata_i[31:16];
    assign lo_compressed   = (fetch_lo[1:0] != 2'b11);
    assign hi_compressed   = (fetch_hi[1:0] != 2'b11);
    assign res_compressed  = (res_q[1:0] != 2'b11);
    assign fetch_res_addr  = {fetch_addr_i[ADDR_WIDTH-1:2], 2'b10};
    assign unused_addr_bit = fetch_addr_i[0];

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        res_addr_d = res_addr_q;
        res_hwlp_d = res_hwlp_q;
        valid      = 1'b0;
        pop        = 1'b0;
        rdata      = 32'h0;
        addr       = '0;
        hwlp       = 1'b0;

        if (clear_i) begin
            state_d    = ALIGNED;
            res_d      = 16'h0;
            res_addr_d = '0;
            res_hwlp_d = 1'b0;
        end else begin
            case (state_q)
                ALIGNED: begin
                    if (fetch_valid_i) begin
                        if (!fetch_addr_i[1]) begin
                            valid = 1'b1;
                            addr  = fetch_addr_i;
                            hwlp  = fetch_is_hwlp_i;
                            if (lo_compressed) begin
                                rdata = {16'h0, fetch_lo};
                                if (instr_ready_i) begin
                                    pop        = 1'b1;
                                    res_d      = fetch_hi;
                                    res_addr_d = fetch_res_addr;
                                    res_hwlp_d = fetch_is_hwlp_i;
                                    state_d    = RESIDUE;
                                end
                            end else begin
                                rdata = fetch_rdata_i;
                                pop   = instr_ready_i;
                            end
                        end else if (hi_compressed) begin
                            valid = 1'b1;
                            rdata = {16'h0, fetch_hi};
                            addr  = fetch_addr_i;
                            hwlp  = fetch_is_hwlp_i;
                            pop   = instr_ready_i;
                        end else begin
                            // Unaligned 32-bit target: swallow the word into the residue (bubble).
                            pop        = 1'b1;
                            res_d      = fetch_hi;
                            res_addr_d = fetch_res_addr;
                            res_hwlp_d = fetch_is_hwlp_i;
                            state_d    = RESIDUE;
                        end
                    end
                end
                RESIDUE: begin
                    if (res_compressed) begin
                        valid = 1'b1;
                        rdata = {16'h0, res_q};
                        addr  = res_addr_q;
                        hwlp  = res_hwlp_q;
                        if (instr_ready_i) begin
                            state_d = ALIGNED;
                        end
                    end else if (fetch_valid_i) begin
                        valid = 1'b1;
                        rdata = {fetch_lo, res_q};
                        addr  = res_addr_q;
                        hwlp  = res_hwlp_q;
                        if (instr_ready_i) begin
                            pop        = 1'b1;
                            res_d      = fetch_hi;
                            res_addr_d = fetch_res_addr;
                            res_hwlp_d = fetch_is_hwlp_i;
                        end
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALIGNED;
            res_q      <= 16'h0;
            res_addr_q <= '0;
            res_hwlp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            res_addr_q <= res_addr_d;
            res_hwlp_q <= res_hwlp_d;
        end
    end

    // Outputs are forced low while reset is asserted, even if a fetch word is presented.
    assign fetch_ready_o         = rst_n & pop;
    assign instr_valid_o         = rst_n & valid;
    assign instr_rdata_o         = rst_n ? rdata : 32'h0;
    assign instr_addr_o          = rst_n ? addr : '0;
    assign instr_is_hwlp_o       = rst_n & hwlp;
    assign instr_is_compressed_o = rst_n & valid & (rdata[1:0] != 2'b11);
    assign residue_valid_o       = rst_n & (state_q == RESIDUE);

endmodule

// File: tb/tb_riscv_instr_realigner.sv
// Bench for riscv_instr_realigner: directed scenarios plus randomized fetch streams
// checked against a halfword-memory program model.
module tb_riscv_instr_realigner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic [31:0] fetch_addr_i = 32'h0;
    logic        fetch_is_hwlp_i = 1'b0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_is_compressed_o;
    logic        instr_is_hwlp_o;
    logic        residue_valid_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic        hw_mem [128];

    riscv_instr_realigner #(.ADDR_WIDTH(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .clear_i               (clear_i),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_ready_o         (fetch_ready_o),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_addr_i          (fetch_addr_i),
        .fetch_is_hwlp_i       (fetch_is_hwlp_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_rdata_o         (instr_rdata_o),
        .instr_addr_o          (instr_addr_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .instr_is_hwlp_o       (instr_is_hwlp_o),
        .residue_valid_o       (residue_valid_o)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [31:0] d, input logic [31:0] a,
                          input logic h, input logic r, input logic c);
        fetch_valid_i   = v;
        fetch_rdata_i   = d;
        fetch_addr_i    = a;
        fetch_is_hwlp_i = h;
        instr_ready_i   = r;
        clear_i         = c;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[8:1]);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        set_in(1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid_o); end
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL rst_fready got %b exp 0", fetch_ready_o); end
        checks++; if (instr_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", instr_rdata_o); end
        checks++; if (instr_is_hwlp_o !== 1'b0) begin errors++; $display("FAIL rst_hwlp got %b exp 0", instr_is_hwlp_o); end
        next_cycle();
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o, residue_valid_o, instr_is_compressed_o, instr_is_hwlp_o} !== 5'b0)
            begin errors++; $display("FAIL post_rst_flags got %b exp 00000", {instr_valid_o, fetch_ready_o, residue_valid_o, instr_is_compressed_o, instr_is_hwlp_o}); end
        checks++; if ({instr_rdata_o, instr_addr_o} !== 64'h0) begin errors++; $display("FAIL post_rst_data got %h exp 0", {instr_rdata_o, instr_addr_o}); end
        next_cycle();
    endtask

    task automatic test_aligned_stream;
        set_in(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o, instr_is_compressed_o} !== 3'b110) begin errors++; $display("FAIL al0_flags got %b exp 110", {instr_valid_o, fetch_ready_o, instr_is_compressed_o}); end
        checks++; if (instr_rdata_o !== 32'h0000_0013 || instr_addr_o !== 32'h0) begin errors++; $display("FAIL al0_instr got %h@%h exp 00000013@0", instr_rdata_o, instr_addr_o); end
        next_cycle();
        set_in(1'b1, 32'h0010_0093, 32'h4, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o, instr_is_compressed_o, instr_is_hwlp_o} !== 4'b1101) begin errors++; $display("FAIL al1_flags got %b exp 1101", {instr_valid_o, fetch_ready_o, instr_is_compressed_o, instr_is_hwlp_o}); end
        checks++; if (instr_rdata_o !== 32'h0010_0093 || instr_addr_o !== 32'h4) begin errors++; $display("FAIL al1_instr got %h@%h exp 00100093@4", instr_rdata_o, instr_addr_o); end
        next_cycle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, residue_valid_o} !== 2'b00) begin errors++; $display("FAIL al_idle got %b exp 00", {instr_valid_o, residue_valid_o}); end
        next_cycle();
    endtask

    task automatic test_compressed_pair;
        set_in(1'b1, 32'h0001_4501, 32'h10, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o, instr_is_compressed_o} !== 3'b111) begin errors++; $display("FAIL cp0_flags got %b exp 111", {instr_valid_o, fetch_ready_o, instr_is_compressed_o}); end
        checks++; if (instr_rdata_o !== 32'h0000_4501 || instr_addr_o !== 32'h10) begin errors++; $display("FAIL cp0_instr got %h@%h exp 00004501@10", instr_rdata_o, instr_addr_o); end
        next_cycle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o, residue_valid_o, instr_is_hwlp_o} !== 4'b1011) begin errors++; $display("FAIL cp1_flags got %b exp 1011", {instr_valid_o, fetch_ready_o, residue_valid_o, instr_is_hwlp_o}); end
        checks++; if (instr_rdata_o !== 32'h0000_0001 || instr_addr_o !== 32'h12) begin errors++; $display("FAIL cp1_instr got %h@%h exp 00000001@12", instr_rdata_o, instr_addr_o); end
        next_cycle();
        @(negedge clk);
        checks++; if ({instr_valid_o, residue_valid_o} !== 2'b00) begin errors++; $display("FAIL cp2_empty got %b exp 00", {instr_valid_o, residue_valid_o}); end
        next_cycle();
    endtask

    task automatic test_spanning;
        set_in(1'b1, 32'h0093_4501, 32'h20, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_rdata_o !== 32'h0000_4501 || instr_addr_o !== 32'h20 || fetch_ready_o !== 1'b1) begin errors++; $display("FAIL sp0 got %h@%h pop %b exp 00004501@20 pop 1", instr_rdata_o, instr_addr_o, fetch_ready_o); end
        next_cycle();
        set_in(1'b1, 32'h4113_0000, 32'h24, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o, instr_is_compressed_o, instr_is_hwlp_o} !== 4'b1100) begin errors++; $display("FAIL sp1_flags got %b exp 1100", {instr_valid_o, fetch_ready_o, instr_is_compressed_o, instr_is_hwlp_o}); end
        checks++; if (instr_rdata_o !== 32'h0000_0093 || instr_addr_o !== 32'h22) begin errors++; $display("FAIL sp1_instr got %h@%h exp 00000093@22", instr_rdata_o, instr_addr_o); end
        next_cycle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o, residue_valid_o} !== 3'b001) begin errors++; $display("FAIL sp2_wait got %b exp 001", {instr_valid_o, fetch_ready_o, residue_valid_o}); end
        next_cycle();
        set_in(1'b1, 32'h0005_0000, 32'h28, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_rdata_o !== 32'h0000_4113 || instr_addr_o !== 32'h26 || instr_is_hwlp_o !== 1'b1) begin errors++; $display("FAIL sp3 got %h@%h hw %b exp 00004113@26 hw 1", instr_rdata_o, instr_addr_o, instr_is_hwlp_o); end
        next_cycle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o} !== 2'b00) begin errors++; $display("FAIL sp_clear got %b exp 00", {instr_valid_o, fetch_ready_o}); end
        next_cycle();
        clear_i = 1'b0;
    endtask

    task automatic test_unaligned_branch;
        set_in(1'b1, 32'h0093_ABCD, 32'h102, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o} !== 2'b01) begin errors++; $display("FAIL ub_bubble got %b exp 01", {instr_valid_o, fetch_ready_o}); end
        next_cycle();
        set_in(1'b1, 32'h0000_0000, 32'h104, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_rdata_o !== 32'h0000_0093 || instr_addr_o !== 32'h102 || fetch_ready_o !== 1'b1) begin errors++; $display("FAIL ub_instr got %h@%h pop %b exp 00000093@102 pop 1", instr_rdata_o, instr_addr_o, fetch_ready_o); end
        next_cycle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_rdata_o !== 32'h0 || instr_addr_o !== 32'h106 || {instr_valid_o, instr_is_compressed_o} !== 2'b11) begin errors++; $display("FAIL ub_tail got %h@%h exp 00000000@106 compressed", instr_rdata_o, instr_addr_o); end
        next_cycle();
    endtask

    task automatic test_backpressure_flush;
        set_in(1'b1, 32'h0001_4501, 32'h10, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b1, 32'hDEAD_BEEF, 32'h14, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({instr_valid_o, fetch_ready_o, residue_valid_o} !== 3'b101 || instr_rdata_o !== 32'h1 || instr_addr_o !== 32'h12)
                begin errors++; $display("FAIL bp_hold%0d got v%b p%b r%b %h@%h exp v1 p0 r1 00000001@12", i, instr_valid_o, fetch_ready_o, residue_valid_o, instr_rdata_o, instr_addr_o); end
            next_cycle();
        end
        set_in(1'b1, 32'hDEAD_BEEF, 32'h14, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if ({instr_valid_o, fetch_ready_o} !== 2'b00) begin errors++; $display("FAIL bp_clear got %b exp 00", {instr_valid_o, fetch_ready_o}); end
        next_cycle();
        set_in(1'b1, 32'h0000_0013, 32'h200, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (residue_valid_o !== 1'b0) begin errors++; $display("FAIL bp_res_cleared got %b exp 0", residue_valid_o); end
        checks++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== 32'h13 || instr_addr_o !== 32'h200) begin errors++; $display("FAIL bp_new got v%b %h@%h exp v1 00000013@200", instr_valid_o, instr_rdata_o, instr_addr_o); end
        next_cycle();
    endtask

    task automatic test_async_reset;
        set_in(1'b1, 32'h0001_4501, 32'h10, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if ({residue_valid_o, instr_valid_o} !== 2'b11) begin errors++; $display("FAIL ar_pre got %b exp 11", {residue_valid_o, instr_valid_o}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({residue_valid_o, instr_valid_o} !== 2'b00) begin errors++; $display("FAIL ar_during got %b exp 00", {residue_valid_o, instr_valid_o}); end
        next_cycle();
        rst_n = 1'b1;
        set_in(1'b1, 32'h0000_0013, 32'h300, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== 32'h13 || instr_addr_o !== 32'h300 || residue_valid_o !== 1'b0)
            begin errors++; $display("FAIL ar_after got v%b %h@%h r%b exp v1 00000013@300 r0", instr_valid_o, instr_rdata_o, instr_addr_o, residue_valid_o); end
        next_cycle();
    endtask

    task automatic test_random;
        logic [31:0] e_data [16];
        logic [31:0] e_addr [16];
        logic        e_comp [16];
        logic        e_hw   [16];
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 128; i++) hw_mem[i] = 1'($urandom);
        for (int seg = 0; seg < 30; seg++) begin
            logic [31:0] start, pc, fptr, w;
            logic [15:0] h0;
            int n, got, cyc;
            start = (seg == 7) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 255)) * 2;
            n = $urandom_range(1, 12);
            pc = start;
            for (int k = 0; k < n; k++) begin
                h0 = mem[idx(pc)];
                e_addr[k] = pc;
                e_hw[k]   = hw_mem[pc[8:2]];
                if (h0[1:0] != 2'b11) begin
                    e_data[k] = {16'h0, h0};
                    e_comp[k] = 1'b1;
                    pc = pc + 2;
                end else begin
                    e_data[k] = {mem[idx(pc + 2)], h0};
                    e_comp[k] = 1'b0;
                    pc = pc + 4;
                end
            end
            fptr = start;
            got = 0;
            cyc = 0;
            while (got < n && cyc < 300) begin
                w = {fptr[31:2], 2'b00};
                set_in($urandom_range(0, 3) != 0, {mem[idx(w + 2)], mem[idx(w)]}, fptr,
                       hw_mem[w[8:2]], $urandom_range(0, 3) != 0, 1'b0);
                @(negedge clk);
                if (fetch_ready_o && !fetch_valid_i) begin checks++; errors++; $display("FAIL rnd_pop_without_valid seg %0d", seg); end
                if (residue_valid_o && instr_valid_o && !instr_is_compressed_o && fetch_valid_i) begin
                    checks++;
                    if (fetch_addr_i[1] !== 1'b0 || fetch_addr_i[31:2] !== instr_addr_o[31:2] + 30'd1)
                        begin errors++; $display("FAIL rnd_span_addr got fetch %h exp word after %h", fetch_addr_i, instr_addr_o); end
                end
                if (instr_valid_o && instr_ready_i) begin
                    checks++;
                    if (instr_rdata_o !== e_data[got] || instr_addr_o !== e_addr[got] ||
                        instr_is_compressed_o !== e_comp[got] || instr_is_hwlp_o !== e_hw[got])
                        begin errors++; $display("FAIL rnd_instr seg %0d #%0d got %h@%h c%b h%b exp %h@%h c%b h%b", seg, got,
                                   instr_rdata_o, instr_addr_o, instr_is_compressed_o, instr_is_hwlp_o,
                                   e_data[got], e_addr[got], e_comp[got], e_hw[got]); end
                    got++;
                end
                if (fetch_valid_i && fetch_ready_o) fptr = w + 4;
                next_cycle();
                cyc++;
            end
            if (got < n) begin checks++; errors++; $display("FAIL rnd_timeout seg %0d got %0d exp %0d instrs", seg, got, n); end
            set_in($urandom_range(0, 1) != 0, 32'h0000_0013, 32'h0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if ({instr_valid_o, fetch_ready_o} !== 2'b00) begin errors++; $display("FAIL rnd_clear seg %0d got %b exp 00", seg, {instr_valid_o, fetch_ready_o}); end
            next_cycle();
            clear_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_aligned_stream();
        test_compressed_pair();
        test_spanning();
        test_unaligned_branch();
        test_backpressure_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_instr_realigner.md
Name: riscv_instr_realigner

Overview:
- Sits directly downstream of the instruction prefetch buffer and directly upstream of IF/ID instruction decode.
- Consumes 32-bit fetch words (word-aligned data plus halfword-granular start address) over a valid/ready pop interface.
- Emits one whole RV32IC instruction per handshake: 16-bit compressed or 32-bit, aligned or spanning two fetch words.
- Holds at most one upper-halfword residue between words; flushed on branch/hwloop redirect.

Parameters:
ADDR_WIDTH, 32, width of fetch and instruction addresses.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear_i  in  1  flush residue (branch, hwloop jump, exception redirect)
fetch_valid_i  in  1  prefetch word available
fetch_ready_o  out  1  pop: word consumed this cycle
fetch_rdata_i  in  32  fetch word; bits [15:0] are the lower halfword
fetch_addr_i  in  ADDR_WIDTH  address of first useful halfword; bit[1]=1 means only [31:16] is valid
fetch_is_hwlp_i  in  1  word belongs to a hardware-loop target fetch
instr_valid_o  out  1  instruction valid
instr_ready_i  in  1  decode accepts instruction
instr_rdata_o  out  32  instruction; compressed ones are zero-extended in [31:16]
instr_addr_o  out  ADDR_WIDTH  PC of instruction
instr_is_compressed_o  out  1  instr_rdata_o[1:0] != 2'b11
instr_is_hwlp_o  out  1  hwlp flag of the word holding the first halfword
residue_valid_o  out  1  residue register occupied (status, to controller)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state ALIGNED, res_q=0, res_addr_q=0, res_hwlp_q=0. All outputs 0 while rst_n low and in the first cycle after reset if fetch_valid_i=0.
- Compressed test: a halfword h is compressed iff h[1:0]!=2'b11.
- Residue address: fetch_addr_i with bits[1:0] forced to 2'b10.
- Handshakes: instr handshake is instr_valid_o&instr_ready_i. fetch_ready_o is asserted only together with fetch_valid_i, and a word is popped in the cycle fetch_ready_o=1. All outputs are combinational from state and inputs; there is no added latency.

State ALIGNED (res empty), fetch_valid_i=1:
- addr[1]=0, low half compressed: out {16'h0,rdata[15:0]}, addr. On handshake: pop; res_q<=rdata[31:16]; res_addr_q<=residue address; res_hwlp_q<=is_hwlp; go to RESIDUE.
- addr[1]=0, low half not compressed: out rdata, addr. On handshake: pop; stay ALIGNED.
- addr[1]=1, upper half compressed: out {16'h0,rdata[31:16]}, addr. On handshake: pop; stay ALIGNED.
- addr[1]=1, upper half not compressed: instr_valid_o=0; pop unconditionally; res_q<=rdata[31:16]; go to RESIDUE. This is a one-cycle bubble.
- fetch_valid_i=0: instr_valid_o=0.

State RESIDUE:
- res_q compressed: out {16'h0,res_q}, res_addr_q, res_hwlp_q, independent of fetch_valid_i. No pop. On handshake go to ALIGNED.
- res_q not compressed: valid only when fetch_valid_i. Out {rdata[15:0],res_q}, addr res_addr_q, hwlp res_hwlp_q. On handshake: pop; res_q<=rdata[31:16]; res_addr_q<=fetch_addr+2 (word-aligned+2); res_hwlp_q<=is_hwlp; stay RESIDUE.
- Protocol invariant (asserted in bench): in this case fetch_addr_i[1]=0 and fetch_addr_i[ADDR_WIDTH-1:2]==res_addr_q[ADDR_WIDTH-1:2]+1. Word-address wrap from all-ones to 0 is permitted.

clear_i:
- Highest priority: instr_valid_o=0 and fetch_ready_o=0 in that cycle.
- Next state ALIGNED; residue registers zeroed.
- clear_i simultaneous with a would-be handshake performs no transfer.

Hold and stability:
- With instr_ready_i=0, all outputs hold stable while inputs are stable.
- The residue is never overwritten without a pop.

residue_valid_o=(state==RESIDUE).

Test Plan:
- Aligned 32-bit stream: words 0x00000013@0x0, 0x00100093@0x4, ready=1 -> two instrs, addr 0x0/0x4, compressed=0, 1 per cycle, two pops.
- Two compressed in one word: 0x00014501@0x10 -> instr 0x4501@0x10 (pop, residue 0x0001); next cycle 0x0001@0x12 with no pop, residue_valid_o back to 0.
- Spanning 32-bit: word 0x00934501@0x20, word 0x41130000@0x24 -> 0x4501@0x20; then {0x0000,0x0093}=0x00000093@0x22 with pop of the second word; residue 0x4113@0x26.
- Branch to unaligned target: word 0x0093xxxx with addr 0x102 -> bubble cycle (pop, instr_valid_o=0); next word 0x00000000@0x104 -> 0x00000093@0x102.
- Backpressure plus flush: hold instr_ready_i=0 for 3 cycles with a residue -> outputs stable, no pop; assert clear_i -> instr_valid_o=0, residue_valid_o=0 next cycle; new word @0x200 is issued aligned.
- Async reset mid-RESIDUE: drop rst_n between clock edges -> residue_valid_o=0 and instr_valid_o=0 immediately; after release, normal operation.
